// File: rtl/verify_seq_pkg.sv
// Shared types for the response-verify sequencer: FSM state encoding, error codes
// and the slot-width helper used to size index ports.
package verify_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CHECK,
        S_RWAIT,
        S_RADV,
        S_POST,
        S_CMP,
        S_FIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_DUP     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/challenge_match.sv
// Combinational lookup of round j in the challenge list, plus range and
// duplicate validation of the list itself. Entry 0 sits in the MSBs of lc.
module challenge_match
    import verify_seq_pkg::*;
#(
    parameter int T     = 8,
    parameter int TAU   = 4,
    parameter int IDX_W = 5
) (
    input  logic [TAU*IDX_W-1:0]    lc,
    input  logic [IDX_W-1:0]        j,
    output logic                    hit,
    output logic [slot_w(TAU)-1:0]  oslot,
    output logic                    range_err,
    output logic                    dup_err
);

    logic [TAU-1:0][IDX_W-1:0] ent;
    assign ent = lc;

    always_comb begin
        hit       = 1'b0;
        oslot     = '0;
        range_err = 1'b0;
        dup_err   = 1'b0;
        for (int s = 0; s < TAU; s++) begin
            // First match wins; the list is unique once CHECK has passed.
            if (!hit && ent[TAU-1-s] == j) begin
                hit   = 1'b1;
                oslot = slot_w(TAU)'(s);
            end
            if (32'(ent[TAU-1-s]) >= 32'(T))
                range_err = 1'b1;
            for (int t = s + 1; t < TAU; t++) begin
                if (ent[TAU-1-s] == ent[TAU-1-t])
                    dup_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/verify_res_seq.sv
// Response-verify sequencer: pre phases, T engine rounds with commitment buffering,
// post phases and final digest compare. Optional watchdog: VERIFY_TIMEOUT_EN.
module verify_res_seq
    import verify_seq_pkg::*;
#(
    parameter int T           = 8,
    parameter int TAU         = 4,
    parameter int IDX_W       = 5,
    parameter int DIGEST_W    = 256,
    parameter int NPRE        = 2,
    parameter int NPOST       = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TAU*IDX_W-1:0]    lc,
    input  logic [TAU*DIGEST_W-1:0] cv_sig,
    output logic [NPRE-1:0]         pre_start,
    input  logic [NPRE-1:0]         pre_end,
    output logic                    rf_start,
    input  logic                    rf_end,
    output logic                    rf_opened,
    output logic [IDX_W-1:0]        rf_round,
    output logic [slot_w(TAU)-1:0]  rf_oslot,
    output logic [slot_w(T)-1:0]    rf_uslot,
    input  logic [DIGEST_W-1:0]     rf_ch,
    input  logic [DIGEST_W-1:0]     rf_cn,
    input  logic [DIGEST_W-1:0]     rf_cv,
    output logic [T*DIGEST_W-1:0]   ch_vec,
    output logic [T*DIGEST_W-1:0]   cn_vec,
    output logic [T*DIGEST_W-1:0]   cv_vec,
    output logic [NPOST-1:0]        post_start,
    input  logic [NPOST-1:0]        post_end,
    input  logic [DIGEST_W-1:0]     h_calc,
    input  logic [DIGEST_W-1:0]     h_sig,
    output logic                    done,
    output logic                    success,
    output logic [1:0]              err,
    output state_t                  dbg_state
);

    localparam int OS_W = slot_w(TAU);
    localparam int US_W = slot_w(T);

    state_t                         state;
    logic [IDX_W-1:0]               j;
    logic [US_W-1:0]                uslot;
    logic [TAU*IDX_W-1:0]           lc_q;
    logic [T-1:0][DIGEST_W-1:0]     ch_buf, cn_buf, cv_buf;
    logic [TAU-1:0][DIGEST_W-1:0]   cv_sig_a;
    logic                           hit, range_err, dup_err;
    logic [OS_W-1:0]                oslot;
    logic [US_W-1:0]                bidx;
    logic [DIGEST_W-1:0]            cv_pick;
    logic                           pre_hit, post_hit, rf_hit, timeout;

    challenge_match #(.T(T), .TAU(TAU), .IDX_W(IDX_W)) u_match (
        .lc        (lc_q),
        .j         (j),
        .hit       (hit),
        .oslot     (oslot),
        .range_err (range_err),
        .dup_err   (dup_err)
    );

    // Handshake: an end bit only counts while its own start bit is high.
    assign pre_hit  = |(pre_end & pre_start);
    assign post_hit = |(post_end & post_start);
    assign rf_hit   = rf_end & rf_start;

    assign cv_sig_a = cv_sig;
    assign bidx     = US_W'(T - 1) - US_W'(j);
    assign cv_pick  = hit ? cv_sig_a[OS_W'(TAU - 1) - oslot] : rf_cv;

    assign ch_vec    = ch_buf;
    assign cn_vec    = cn_buf;
    assign cv_vec    = cv_buf;
    assign rf_round  = j;
    assign rf_opened = hit;
    assign rf_oslot  = oslot;
    assign rf_uslot  = uslot;
    assign dbg_state = state;

`ifdef VERIFY_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    logic            wait_st;

    assign wait_st = (state == S_PRE) || (state == S_RWAIT) || (state == S_POST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd <= '0;
        else if (!wait_st || pre_hit || rf_hit || post_hit || !start)
            wd <= '0;
        else
            wd <= wd + 1'b1;
    end

    assign timeout = wait_st && (wd == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            j          <= '0;
            uslot      <= '0;
            lc_q       <= '0;
            ch_buf     <= '0;
            cn_buf     <= '0;
            cv_buf     <= '0;
            pre_start  <= '0;
            post_start <= '0;
            rf_start   <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            err        <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        success <= 1'b0;
                        err     <= ERR_NONE;
                    end else if (!done) begin
                        pre_start <= NPRE'(1);
                        state     <= S_PRE;
                    end
                end
                S_FIN: begin
                    if (!start)
                        state <= S_IDLE;
                end
                default: begin
                    if (!start) begin
                        // Abort: buffers and result flags are left untouched.
                        pre_start  <= '0;
                        post_start <= '0;
                        rf_start   <= 1'b0;
                        state      <= S_IDLE;
                    end else if (timeout) begin
                        pre_start  <= '0;
                        post_start <= '0;
                        rf_start   <= 1'b0;
                        err        <= ERR_TIMEOUT;
                        success    <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        case (state)
                            S_PRE: if (pre_hit) begin
                                if (pre_start[0])
                                    lc_q <= lc;
                                if (pre_start[NPRE-1]) begin
                                    pre_start <= '0;
                                    state     <= S_CHECK;
                                end else begin
                                    pre_start <= pre_start << 1;
                                end
                            end
                            S_CHECK: begin
                                if (range_err) begin
                                    err   <= ERR_RANGE;
                                    done  <= 1'b1;
                                    state <= S_FIN;
                                end else if (dup_err) begin
                                    err   <= ERR_DUP;
                                    done  <= 1'b1;
                                    state <= S_FIN;
                                end else begin
                                    j        <= '0;
                                    uslot    <= '0;
                                    rf_start <= 1'b1;
                                    state    <= S_RWAIT;
                                end
                            end
                            S_RWAIT: if (rf_hit) begin
                                rf_start     <= 1'b0;
                                ch_buf[bidx] <= rf_ch;
                                cn_buf[bidx] <= rf_cn;
                                cv_buf[bidx] <= cv_pick;
                                if (!hit)
                                    uslot <= uslot + 1'b1;
                                state <= S_RADV;
                            end
                            S_RADV: begin
                                if (j == IDX_W'(T - 1)) begin
                                    j          <= '0;
                                    uslot      <= '0;
                                    post_start <= NPOST'(1);
                                    state      <= S_POST;
                                end else begin
                                    j        <= j + 1'b1;
                                    rf_start <= 1'b1;
                                    state    <= S_RWAIT;
                                end
                            end
                            S_POST: if (post_hit) begin
                                if (post_start[NPOST-1]) begin
                                    post_start <= '0;
                                    state      <= S_CMP;
                                end else begin
                                    post_start <= post_start << 1;
                                end
                            end
                            S_CMP: begin
                                success <= (h_calc == h_sig);
                                done    <= 1'b1;
                                state   <= S_FIN;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verify_res_seq.sv
// Randomized scoreboard bench for verify_res_seq: responder engines, a reference
// model of the round schedule and buffers, and a monitor popping expected records.
module tb_verify_res_seq;
    import verify_seq_pkg::*;

    localparam int T        = 8;
    localparam int TAU      = 4;
    localparam int IDX_W    = 5;
    localparam int DIGEST_W = 256;
    localparam int NPRE     = 2;
    localparam int NPOST    = 5;
    localparam int OS_W     = 2;
    localparam int US_W     = 3;
    localparam int REC_W    = IDX_W + 1 + OS_W + US_W;
`ifdef VERIFY_TIMEOUT_EN
    localparam int TO_CYC   = 16;
`else
    localparam int TO_CYC   = 4096;
`endif

    logic                    clk, reset, start;
    logic [TAU*IDX_W-1:0]    lc;
    logic [TAU*DIGEST_W-1:0] cv_sig;
    logic [NPRE-1:0]         pre_start, pre_end;
    logic                    rf_start, rf_end, rf_opened;
    logic [IDX_W-1:0]        rf_round;
    logic [OS_W-1:0]         rf_oslot;
    logic [US_W-1:0]         rf_uslot;
    logic [DIGEST_W-1:0]     rf_ch, rf_cn, rf_cv, h_calc, h_sig;
    logic [T*DIGEST_W-1:0]   ch_vec, cn_vec, cv_vec;
    logic [NPOST-1:0]        post_start, post_end, post_stuck;
    logic                    done, success;
    logic [1:0]              err;
    state_t                  dbg_state;

    logic [DIGEST_W-1:0] eng_ch[T], eng_cn[T], eng_cv[T], sig_cv[TAU];
    logic [DIGEST_W-1:0] exp_ch[T], exp_cn[T], exp_cv[T];
    logic [REC_W-1:0]    exp_q[$];
    logic [2:0]          res_q[$];
    int                  n_checks = 0;
    int                  n_pass   = 0;

    verify_res_seq #(
        .T(T), .TAU(TAU), .IDX_W(IDX_W), .DIGEST_W(DIGEST_W),
        .NPRE(NPRE), .NPOST(NPOST), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .lc(lc), .cv_sig(cv_sig),
        .pre_start(pre_start), .pre_end(pre_end),
        .rf_start(rf_start), .rf_end(rf_end), .rf_opened(rf_opened),
        .rf_round(rf_round), .rf_oslot(rf_oslot), .rf_uslot(rf_uslot),
        .rf_ch(rf_ch), .rf_cn(rf_cn), .rf_cv(rf_cv),
        .ch_vec(ch_vec), .cn_vec(cn_vec), .cv_vec(cv_vec),
        .post_start(post_start), .post_end(post_end),
        .h_calc(h_calc), .h_sig(h_sig),
        .done(done), .success(success), .err(err), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DIGEST_W-1:0] act,
                         input logic [DIGEST_W-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [DIGEST_W-1:0] rand_d();
        logic [DIGEST_W-1:0] r;
        for (int i = 0; i < DIGEST_W / 32; i++)
            r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [TAU*IDX_W-1:0] mk_lc(input int a, input int b, input int c, input int d);
        return {IDX_W'(a), IDX_W'(b), IDX_W'(c), IDX_W'(d)};
    endfunction

    // Sub-engine responders: each end pulses after a random 0..3 cycle delay.
    initial begin : engines
        int rf_cnt, pre_cnt, post_cnt;
        logic rf_prev;
        logic [NPRE-1:0] pre_prev;
        logic [NPOST-1:0] post_prev;
        rf_cnt = 0; pre_cnt = 0; post_cnt = 0;
        rf_prev = 1'b0; pre_prev = '0; post_prev = '0;
        rf_end = 1'b0; pre_end = '0; post_end = '0;
        rf_ch = '0; rf_cn = '0; rf_cv = '0;
        forever begin
            @(negedge clk);
            rf_end = 1'b0;
            if (rf_start) begin
                if (!rf_prev) rf_cnt = $urandom_range(0, 3);
                if (rf_cnt == 0) begin
                    rf_end = 1'b1;
                    rf_ch  = eng_ch[int'(rf_round)];
                    rf_cn  = eng_cn[int'(rf_round)];
                    rf_cv  = eng_cv[int'(rf_round)];
                end else begin
                    rf_cnt--;
                end
            end
            rf_prev = rf_start;
            pre_end = '0;
            if (pre_start != pre_prev) pre_cnt = $urandom_range(0, 3);
            if (pre_start != '0) begin
                if (pre_cnt == 0) pre_end = pre_start;
                else pre_cnt--;
            end
            pre_prev = pre_start;
            post_end = '0;
            if (post_start != post_prev) post_cnt = $urandom_range(0, 3);
            if (post_start != '0) begin
                if (post_cnt == 0) post_end = post_start & ~post_stuck;
                else post_cnt--;
            end
            post_prev = post_start;
        end
    end

    // Monitor: pops a round record on each rf_start rise, a result on each done rise.
    initial begin : monitor
        logic rf_d, done_d;
        logic [REC_W-1:0] rec;
        logic [2:0] res;
        rf_d = 1'b0; done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rf_start && !rf_d) begin
                rec = {rf_round, rf_opened, rf_opened ? rf_oslot : OS_W'(0), rf_uslot};
                if (exp_q.size() == 0) begin
                    check("round_unexpected", DIGEST_W'(rec), '1);
                end else begin
                    check($sformatf("round_rec j=%0d", rf_round), DIGEST_W'(rec),
                          DIGEST_W'(exp_q.pop_front()));
                end
            end
            if (done && !done_d) begin
                res = {success, err};
                if (res_q.size() == 0)
                    check("done_unexpected", DIGEST_W'(res), '1);
                else
                    check("result", DIGEST_W'(res), DIGEST_W'(res_q.pop_front()));
            end
            rf_d = rf_start;
            done_d = done;
        end
    end

    // One verify: builds data, predicts the schedule, runs, checks buffers.
    task automatic run_verify(input string tag, input logic [TAU*IDX_W-1:0] lcv,
                              input bit h_ok, input bit directed, input int abort_round,
                              input bit expect_to);
        int e[TAU];
        int err_m, us, pos, last, cyc, p1;
        bit got, found;
        for (int k = 0; k < T; k++) begin
            eng_ch[k] = directed ? DIGEST_W'(k + 16) : rand_d();
            eng_cn[k] = rand_d();
            eng_cv[k] = rand_d();
        end
        for (int s = 0; s < TAU; s++) begin
            sig_cv[s] = rand_d();
            cv_sig[(TAU-1-s)*DIGEST_W +: DIGEST_W] = sig_cv[s];
            e[s] = int'(lcv[(TAU-1-s)*IDX_W +: IDX_W]);
        end
        h_sig = rand_d();
        h_calc = h_ok ? h_sig : (h_sig ^ DIGEST_W'(1));
        lc = lcv;
        post_stuck = expect_to ? NPOST'(2) : '0;

        err_m = 0;
        for (int s = 0; s < TAU; s++) if (e[s] >= T) err_m = 1;
        if (err_m == 0)
            for (int s = 0; s < TAU; s++)
                for (int t = s + 1; t < TAU; t++)
                    if (e[s] == e[t]) err_m = 2;
        if (err_m == 0) begin
            us = 0;
            last = (abort_round >= 0) ? abort_round : T - 1;
            for (int k = 0; k < T; k++) begin
                pos = -1;
                for (int s = 0; s < TAU; s++) if (e[s] == k) pos = s;
                if (k <= last)
                    exp_q.push_back({IDX_W'(k), pos >= 0, OS_W'(pos >= 0 ? pos : 0), US_W'(us)});
                exp_ch[k] = eng_ch[k];
                exp_cn[k] = eng_cn[k];
                exp_cv[k] = (pos >= 0) ? sig_cv[pos] : eng_cv[k];
                if (pos < 0) us++;
            end
        end
        if (abort_round < 0)
            res_q.push_back(expect_to ? 3'b011 : {h_ok && err_m == 0, 2'(err_m)});

        start = 1'b1;
        if (abort_round >= 0) begin
            found = 1'b0;
            for (int c = 0; c < 400 && !found; c++) begin
                @(negedge clk);
                if (rf_start && int'(rf_round) == abort_round) found = 1'b1;
            end
            check({tag, " abort_point_seen"}, DIGEST_W'(found), DIGEST_W'(1));
            start = 1'b0;
            @(posedge clk); #1;
            check({tag, " abort_rf_start"}, DIGEST_W'(rf_start), '0);
            check({tag, " abort_state"}, DIGEST_W'(dbg_state), DIGEST_W'(S_IDLE));
            check({tag, " abort_done"}, DIGEST_W'(done), '0);
            repeat (3) @(negedge clk);
            check({tag, " abort_q_empty"}, DIGEST_W'(exp_q.size()), '0);
            return;
        end

        got = 1'b0; cyc = 0; p1 = 0;
        while (cyc < 2000 && !got) begin
            @(negedge clk);
            cyc++;
            if (post_start[1]) p1++;
            if (done) got = 1'b1;
        end
        check({tag, " done_seen"}, DIGEST_W'(got), DIGEST_W'(1));
        @(negedge clk);
        check({tag, " done_held"}, DIGEST_W'(done), DIGEST_W'(got));
        check({tag, " round_q_empty"}, DIGEST_W'(exp_q.size()), '0);
        check({tag, " res_q_empty"}, DIGEST_W'(res_q.size()), '0);
        if (expect_to)
            check({tag, " post1_cycles"}, DIGEST_W'(p1), DIGEST_W'(TO_CYC));
        if (err_m == 0) begin
            for (int k = 0; k < T; k++) begin
                check($sformatf("%s ch_vec[%0d]", tag, k), ch_vec[(T-1-k)*DIGEST_W +: DIGEST_W], exp_ch[k]);
                check($sformatf("%s cn_vec[%0d]", tag, k), cn_vec[(T-1-k)*DIGEST_W +: DIGEST_W], exp_cn[k]);
                check($sformatf("%s cv_vec[%0d]", tag, k), cv_vec[(T-1-k)*DIGEST_W +: DIGEST_W], exp_cv[k]);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " idle_done_clr"}, DIGEST_W'({done, success, err}), '0);
        exp_q.delete();
        res_q.delete();
    endtask

    initial begin : main
        int v[TAU];
        bit used[T];
        reset = 1'b0; start = 1'b0; lc = '0; cv_sig = '0;
        h_calc = '0; h_sig = '0; post_stuck = '0;
        repeat (3) @(negedge clk);
        check("reset_done", DIGEST_W'(done), '0);
        check("reset_success", DIGEST_W'(success), '0);
        check("reset_err", DIGEST_W'(err), '0);
        check("reset_starts", DIGEST_W'({pre_start, rf_start, post_start}), '0);
        check("reset_buffers_zero", DIGEST_W'(|{ch_vec, cn_vec, cv_vec}), '0);
        check("reset_state", DIGEST_W'(dbg_state), DIGEST_W'(S_IDLE));
        check("reset_uslot", DIGEST_W'({rf_round, rf_uslot}), '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_verify("sorted",   mk_lc(1, 3, 4, 6), 1'b1, 1'b1, -1, 1'b0);
        run_verify("unsorted", mk_lc(6, 1, 4, 3), 1'b1, 1'b1, -1, 1'b0);
        run_verify("dup",      mk_lc(1, 3, 3, 6), 1'b1, 1'b0, -1, 1'b0);
        run_verify("range",    mk_lc(1, 9, 4, 6), 1'b1, 1'b0, -1, 1'b0);
        run_verify("abort",    mk_lc(1, 3, 4, 6), 1'b1, 1'b0,  2, 1'b0);
        run_verify("restart",  mk_lc(1, 3, 4, 6), 1'b1, 1'b0, -1, 1'b0);
        run_verify("h_mism",   mk_lc(0, 7, 2, 5), 1'b0, 1'b0, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < T; k++) used[k] = 1'b0;
            for (int s = 0; s < TAU; s++) begin
                do v[s] = $urandom_range(0, T - 1); while (used[v[s]]);
                used[v[s]] = 1'b1;
            end
            run_verify($sformatf("rand%0d", r), mk_lc(v[0], v[1], v[2], v[3]),
                       1'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
        end

`ifdef VERIFY_TIMEOUT_EN
        run_verify("timeout", mk_lc(2, 0, 5, 7), 1'b1, 1'b0, -1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
